pipe_wb_regfile: RTL and testbench
==================================

// Module: pipe_wb_regfile
// PURPOSE
//  Write-back stage and register file of the 5-stage pipeline. Consumes the MEM/WB
//  pipeline-register outputs (wreg, m2reg, mo, alu, rn), selects the write-back
//  value, commits it to a 2R1W register file, and serves the ID stage's two operand
//  reads with write-first bypass. Also keeps a retired-write counter and a debug
//  read port for the bench and board display.
// PARAMETERS
//  DW   32  data width of registers and write-back path
//  AW   5   register address width; file holds 2**AW entries, entry 0 hardwired to 0
//  CW   32  width of retired-write counter
// PORTS
//  clk        in   1   clock; all state updates on posedge
//  rst        in   1   reset, synchronous, active-high
//  i_wreg     in   1   MEM/WB: instruction writes a register
//  i_m2reg    in   1   MEM/WB: 1 = write memory data, 0 = write ALU result
//  i_mo       in   DW  MEM/WB: memory read data
//  i_alu      in   DW  MEM/WB: ALU result
//  i_rn       in   AW  MEM/WB: destination register number
//  i_ra       in   AW  ID: read address A (rs)
//  i_rb       in   AW  ID: read address B (rt)
//  i_dbg_a    in   AW  debug read address
//  o_wdata    out  DW  selected write-back value (combinational, for forwarding)
//  o_we       out  1   effective write enable: i_wreg & (i_rn != 0) & !rst
//  o_qa       out  DW  read data A
//  o_qb       out  DW  read data B
//  o_dbg_q    out  DW  debug read data (no bypass: committed contents only)
//  o_wcount   out  CW  number of committed register writes since reset
// BEHAVIOUR
//  - Reset: rst sampled at posedge clears all 2**AW entries and o_wcount to 0.
//    While rst=1: o_we=0, o_qa=o_qb=o_dbg_q=0; o_wdata still follows the mux.
//    Reset wins over a simultaneous write; the write is dropped, not deferred.
//  - Write-back mux: o_wdata = i_m2reg ? i_mo : i_alu, zero latency.
//  - Commit: at posedge with o_we=1, reg[i_rn] <= o_wdata; o_wcount <= o_wcount+1,
//    wrapping modulo 2**CW (all-ones + 1 -> 0). Writes to r0 are discarded and
//    are not counted.
//  - Reads combinational. addr 0 -> 0 always. If o_we=1 and i_ra==i_rn then
//    o_qa=o_wdata (write-first bypass, removes the WB->ID hazard); same for B.
//    Both ports may hit the bypass in the same cycle.
//  - No stall/flush input: a bubble arrives as i_wreg=0 from the MEM/WB register.
//  - No X propagation: every output defined in every cycle after first reset edge.
// STRUCTURE
//  - Shared package pipe_pkg: DW, AW, REG_ZERO ('0 address), reset constants;
//    also used by the pipeline registers and the forwarding unit.
//  - One sub-module: regfile_2r1w (array, r0 suppression, write port, 2 read
//    ports, debug port). Top holds the WB mux, bypass compare and counter.
// TESTING
//  1 rst=1 two cycles -> every o_dbg_q(0..31)=0, o_wcount=0, o_we=0.
//  2 wreg=1,m2reg=0,alu=32'h1234_5678,rn=5; next cycle dbg_a=5 -> 32'h1234_5678,
//    o_wcount=1. Repeat with m2reg=1,mo=32'hDEAD_BEEF,rn=6 -> reg6=DEAD_BEEF.
//  3 Bypass: wreg=1,rn=7,alu=32'hA5A5_0001,ra=rb=7 same cycle -> o_qa=o_qb=
//    A5A5_0001 before the edge; dbg_a=7 still shows old value until the edge.
//  4 r0: wreg=1,rn=0,alu=32'hFFFF_FFFF,ra=0 -> o_qa=0, o_we=0, reg0 stays 0,
//    o_wcount unchanged; wreg=0,rn=9 -> reg9 unchanged.
//  5 rst=1 together with wreg=1,rn=3,alu=32'h55 -> reg3=0, o_wcount=0 after edge,
//    o_qa(ra=3)=0 during the reset cycle.
//  6 Force o_wcount to all-ones (CW=4 build: 15), one valid write -> o_wcount=0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline constants: datapath/address widths, the hardwired-zero register
// number and the reset values used by the pipeline registers and forwarding unit.
package pipe_pkg;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int CW = 32;

    localparam logic [AW-1:0] REG_ZERO = '0;
    localparam logic [DW-1:0] RST_DATA = '0;
    localparam logic [CW-1:0] RST_COUNT = '0;

    // True when a write to this destination actually lands in the file.
    function automatic logic writes_reg(input logic wreg, input logic [AW-1:0] rn);
        return wreg && (rn != REG_ZERO);
    endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// 2**AW x DW register file: one write port, two operand read ports and a debug port.
// Entry 0 always reads as zero; reset clears every entry.
module regfile_2r1w #(
    parameter int DW = pipe_pkg::DW,
    parameter int AW = pipe_pkg::AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] ra,
    input  logic [AW-1:0] rb,
    input  logic [AW-1:0] dbg_a,
    output logic [DW-1:0] qa,
    output logic [DW-1:0] qb,
    output logic [DW-1:0] dbg_q
);
    import pipe_pkg::*;

    localparam int NREG = 2 ** AW;
    localparam logic [AW-1:0] ZERO_A = AW'(REG_ZERO);

    logic [DW-1:0] mem_q [NREG];
    logic [DW-1:0] mem_d [NREG];

    always_comb begin
        mem_d = mem_q;
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                mem_d[i] = '0;
            end
        end else if (we && (waddr != ZERO_A)) begin
            mem_d[waddr] = wdata;
        end
        mem_d[0] = '0;
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Reads are forced to zero during reset so nothing undefined leaks before the clear.
    always_comb begin
        qa    = (rst || ra == ZERO_A)    ? '0 : mem_q[ra];
        qb    = (rst || rb == ZERO_A)    ? '0 : mem_q[rb];
        dbg_q = (rst || dbg_a == ZERO_A) ? '0 : mem_q[dbg_a];
    end

endmodule

// File: rtl/pipe_wb_regfile.sv
// Write-back stage: selects the write-back value, commits it to the register file,
// bypasses same-cycle writes onto the ID read ports and counts retired writes.
module pipe_wb_regfile #(
    parameter int DW = pipe_pkg::DW,
    parameter int AW = pipe_pkg::AW,
    parameter int CW = pipe_pkg::CW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_wreg,
    input  logic          i_m2reg,
    input  logic [DW-1:0] i_mo,
    input  logic [DW-1:0] i_alu,
    input  logic [AW-1:0] i_rn,
    input  logic [AW-1:0] i_ra,
    input  logic [AW-1:0] i_rb,
    input  logic [AW-1:0] i_dbg_a,
    output logic [DW-1:0] o_wdata,
    output logic          o_we,
    output logic [DW-1:0] o_qa,
    output logic [DW-1:0] o_qb,
    output logic [DW-1:0] o_dbg_q,
    output logic [CW-1:0] o_wcount
);
    import pipe_pkg::*;

    localparam logic [AW-1:0] ZERO_A = AW'(REG_ZERO);

    logic [DW-1:0] rf_qa;
    logic [DW-1:0] rf_qb;
    logic [DW-1:0] rf_dbg_q;
    logic          hit_a;
    logic          hit_b;
    logic [CW-1:0] wcount_q;
    logic [CW-1:0] wcount_d;

    always_comb begin
        o_wdata = i_m2reg ? i_mo : i_alu;
        o_we    = i_wreg && (i_rn != ZERO_A) && !rst;
    end

    regfile_2r1w #(
        .DW(DW),
        .AW(AW)
    ) u_rf (
        .clk  (clk),
        .rst  (rst),
        .we   (o_we),
        .waddr(i_rn),
        .wdata(o_wdata),
        .ra   (i_ra),
        .rb   (i_rb),
        .dbg_a(i_dbg_a),
        .qa   (rf_qa),
        .qb   (rf_qb),
        .dbg_q(rf_dbg_q)
    );

    // o_we already excludes r0 and reset, so a hit implies a nonzero, live address.
    always_comb begin
        hit_a   = o_we && (i_ra == i_rn);
        hit_b   = o_we && (i_rb == i_rn);
        o_qa    = hit_a ? o_wdata : rf_qa;
        o_qb    = hit_b ? o_wdata : rf_qb;
        o_dbg_q = rf_dbg_q;
    end

    always_comb begin
        wcount_d = wcount_q;
        if (rst) begin
            wcount_d = '0;
        end else if (o_we) begin
            wcount_d = wcount_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        wcount_q <= wcount_d;
    end

    assign o_wcount = wcount_q;

endmodule

// File: tb/tb_pipe_wb_regfile.sv
// Bench for pipe_wb_regfile: directed scenarios plus randomized traffic, checked
// every cycle against an array-based model of the register file and counters.
`timescale 1ns/1ps
module tb_pipe_wb_regfile;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          i_wreg = 1'b0;
    logic          i_m2reg = 1'b0;
    logic [DW-1:0] i_mo = '0;
    logic [DW-1:0] i_alu = '0;
    logic [AW-1:0] i_rn = '0;
    logic [AW-1:0] i_ra = '0;
    logic [AW-1:0] i_rb = '0;
    logic [AW-1:0] i_dbg_a = '0;

    logic [DW-1:0] o_wdata, o_qa, o_qb, o_dbg_q;
    logic          o_we;
    logic [31:0]   o_wcount;

    logic [DW-1:0] s_wdata, s_qa, s_qb, s_dbg_q;
    logic          s_we;
    logic [3:0]    s_wcount;

    pipe_wb_regfile #(.DW(DW), .AW(AW), .CW(32)) dut (
        .clk(clk), .rst(rst), .i_wreg(i_wreg), .i_m2reg(i_m2reg), .i_mo(i_mo),
        .i_alu(i_alu), .i_rn(i_rn), .i_ra(i_ra), .i_rb(i_rb), .i_dbg_a(i_dbg_a),
        .o_wdata(o_wdata), .o_we(o_we), .o_qa(o_qa), .o_qb(o_qb),
        .o_dbg_q(o_dbg_q), .o_wcount(o_wcount)
    );

    pipe_wb_regfile #(.DW(DW), .AW(AW), .CW(4)) dut_small (
        .clk(clk), .rst(rst), .i_wreg(i_wreg), .i_m2reg(i_m2reg), .i_mo(i_mo),
        .i_alu(i_alu), .i_rn(i_rn), .i_ra(i_ra), .i_rb(i_rb), .i_dbg_a(i_dbg_a),
        .o_wdata(s_wdata), .o_we(s_we), .o_qa(s_qa), .o_qb(s_qb),
        .o_dbg_q(s_dbg_q), .o_wcount(s_wcount)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the architectural register contents and write counts.
    logic [DW-1:0] m_reg [32];
    logic [31:0]   m_cnt = '0;
    logic [3:0]    m_cnt4 = '0;
    bit            started = 1'b0;

    function automatic logic [DW-1:0] exp_wdata();
        return i_m2reg ? i_mo : i_alu;
    endfunction

    function automatic logic exp_we();
        return i_wreg && (i_rn != 0) && !rst;
    endfunction

    function automatic logic [DW-1:0] exp_read(input logic [AW-1:0] a, input bit bypass);
        if (rst || a == 0) return '0;
        if (bypass && exp_we() && a == i_rn) return exp_wdata();
        return m_reg[a];
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) m_reg[i] = '0;
            m_cnt   = '0;
            m_cnt4  = '0;
            started = 1'b1;
        end else if (started && exp_we()) begin
            m_reg[i_rn] = exp_wdata();
            m_cnt  = m_cnt + 1;
            m_cnt4 = m_cnt4 + 4'd1;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("wdata",   o_wdata,  exp_wdata());
            check("we",      o_we,     exp_we());
            check("qa",      o_qa,     exp_read(i_ra, 1'b1));
            check("qb",      o_qb,     exp_read(i_rb, 1'b1));
            check("dbg_q",   o_dbg_q,  exp_read(i_dbg_a, 1'b0));
            check("wcount",  o_wcount, m_cnt);
            check("s_we",    s_we,     exp_we());
            check("s_qa",    s_qa,     exp_read(i_ra, 1'b1));
            check("s_wcount", s_wcount, m_cnt4);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic m2r, input logic [DW-1:0] d, input logic [AW-1:0] rn);
        i_wreg  = 1'b1;
        i_m2reg = m2r;
        i_mo    = m2r ? d : 32'h0BAD_0BAD;
        i_alu   = m2r ? 32'h0BAD_0BAD : d;
        i_rn    = rn;
    endtask

    initial begin
        // 1: reset for two cycles, then every entry reads zero.
        rst = 1'b1;
        step();
        step();
        check("rst_we", o_we, 1'b0);
        rst = 1'b0;
        for (int a = 0; a < 32; a++) begin
            i_dbg_a = AW'(a);
            #1;
            check("rst_dbg", o_dbg_q, 32'h0);
        end
        check("rst_cnt", o_wcount, 32'd0);

        // 2: ALU and memory write-back.
        wr(1'b0, 32'h1234_5678, 5'd5);
        #1;
        check("mux_alu", o_wdata, 32'h1234_5678);
        step();
        i_wreg = 1'b0;
        i_dbg_a = 5'd5;
        #1;
        check("reg5", o_dbg_q, 32'h1234_5678);
        check("cnt1", o_wcount, 32'd1);
        wr(1'b1, 32'hDEAD_BEEF, 5'd6);
        #1;
        check("mux_mem", o_wdata, 32'hDEAD_BEEF);
        step();
        i_wreg = 1'b0;
        i_dbg_a = 5'd6;
        #1;
        check("reg6", o_dbg_q, 32'hDEAD_BEEF);
        check("cnt2", o_wcount, 32'd2);

        // 3: write-first bypass on both ports, debug port sees old contents.
        wr(1'b0, 32'hA5A5_0001, 5'd7);
        i_ra = 5'd7;
        i_rb = 5'd7;
        i_dbg_a = 5'd7;
        #1;
        check("byp_qa", o_qa, 32'hA5A5_0001);
        check("byp_qb", o_qb, 32'hA5A5_0001);
        check("byp_dbg_old", o_dbg_q, 32'h0);
        step();
        i_wreg = 1'b0;
        #1;
        check("byp_dbg_new", o_dbg_q, 32'hA5A5_0001);
        check("cnt3", o_wcount, 32'd3);

        // 4: r0 writes are discarded and not counted; wreg=0 leaves the file alone.
        wr(1'b0, 32'hFFFF_FFFF, 5'd0);
        i_ra = 5'd0;
        #1;
        check("r0_qa", o_qa, 32'h0);
        check("r0_we", o_we, 1'b0);
        step();
        i_wreg = 1'b0;
        i_dbg_a = 5'd0;
        #1;
        check("r0_dbg", o_dbg_q, 32'h0);
        check("r0_cnt", o_wcount, 32'd3);
        i_rn = 5'd9;
        i_alu = 32'h9999_9999;
        step();
        i_dbg_a = 5'd9;
        #1;
        check("reg9", o_dbg_q, 32'h0);

        // 5: reset beats a simultaneous write.
        wr(1'b0, 32'h77, 5'd3);
        step();
        wr(1'b0, 32'h55, 5'd3);
        rst = 1'b1;
        i_ra = 5'd3;
        #1;
        check("rstw_qa", o_qa, 32'h0);
        check("rstw_we", o_we, 1'b0);
        step();
        rst = 1'b0;
        i_wreg = 1'b0;
        i_dbg_a = 5'd3;
        #1;
        check("rstw_reg3", o_dbg_q, 32'h0);
        check("rstw_cnt", o_wcount, 32'd0);

        // 6: the 4-bit counter wraps from 15 to 0.
        for (int n = 1; n <= 15; n++) begin
            wr(1'b0, 32'(n), AW'(n));
            step();
        end
        i_wreg = 1'b0;
        #1;
        check("wrap15", s_wcount, 4'd15);
        wr(1'b0, 32'h1616, 5'd16);
        step();
        i_wreg = 1'b0;
        #1;
        check("wrap0", s_wcount, 4'd0);
        check("nowrap16", o_wcount, 32'd16);

        // Randomized traffic, addresses biased low so bypass hits are frequent.
        for (int c = 0; c < 3000; c++) begin
            rst     = ($urandom_range(0, 99) == 0);
            i_wreg  = ($urandom_range(0, 3) != 0);
            i_m2reg = $urandom_range(0, 1);
            i_mo    = $urandom;
            i_alu   = $urandom;
            i_rn    = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 3)) : AW'($urandom);
            i_ra    = ($urandom_range(0, 1) == 1) ? i_rn : AW'($urandom_range(0, 7));
            i_rb    = ($urandom_range(0, 2) == 0) ? i_rn : AW'($urandom);
            i_dbg_a = AW'($urandom);
            step();
        end

        rst = 1'b0;
        i_wreg = 1'b0;
        step();
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
